// File: rtl/lsu64.sv
// lsu64: MEM-stage load/store initiator for a doubleword-only data memory.
// Loads are extracted from an aligned doubleword and then extended. Sub-doubleword
// stores read the doubleword, merge the new bytes into it, and write it back.
module lsu64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);

    localparam int unsigned DW = 64;
    localparam int unsigned SHW = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  merge_q;
    logic [DW-1:0]  rdata_q;
    logic [2:0]     funct3_q;
    logic           write_q;
    logic           err_q;

    logic           accept_c;
    logic           misalign_c;
    logic           illegal_c;
    logic           req_err_c;
    logic [SHW-1:0] shamt_c;
    logic [DW-1:0]  size_mask_c;
    logic [DW-1:0]  shifted_c;
    logic [DW-1:0]  extended_c;
    logic [DW-1:0]  merged_c;
    logic           sext_c;

    assign accept_c = (state == IDLE) && req_valid;

    // Request checks on the live request, evaluated only for the accept cycle
    always_comb begin
        misalign_c = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign_c = req_addr[0];
            2'b10:   misalign_c = (req_addr[1:0] != 2'b00);
            2'b11:   misalign_c = (req_addr[2:0] != 3'b000);
            default: misalign_c = 1'b0;
        endcase
        illegal_c = (req_write && req_funct3[2]) || (req_funct3 == 3'b111);
        req_err_c = misalign_c || illegal_c;
    end

    // Lane shift, size mask, load extraction and store merge
    always_comb begin
        shamt_c   = {addr_q[2:0], 3'b000};
        shifted_c = mem_read_data >> shamt_c;
        sext_c    = ~funct3_q[2];
        case (funct3_q[1:0])
            2'b00: begin
                size_mask_c = 64'h0000_0000_0000_00FF;
                extended_c  = {{56{sext_c & shifted_c[7]}}, shifted_c[7:0]};
            end
            2'b01: begin
                size_mask_c = 64'h0000_0000_0000_FFFF;
                extended_c  = {{48{sext_c & shifted_c[15]}}, shifted_c[15:0]};
            end
            2'b10: begin
                size_mask_c = 64'h0000_0000_FFFF_FFFF;
                extended_c  = {{32{sext_c & shifted_c[31]}}, shifted_c[31:0]};
            end
            default: begin
                size_mask_c = 64'hFFFF_FFFF_FFFF_FFFF;
                extended_c  = shifted_c;
            end
        endcase
        merged_c = (mem_read_data & ~(size_mask_c << shamt_c))
                 | ((wdata_q & size_mask_c) << shamt_c);
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err_c) begin
                        state_nxt = RESP;
                    end else if (!req_write) begin
                        state_nxt = LOAD;
                    end else if (req_funct3[1:0] == 2'b11) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = RMW_READ;
                    end
                end
            end
            LOAD:     state_nxt = RESP;
            RMW_READ: state_nxt = WRITE;
            WRITE:    state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request latches, load result and merge buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept_c) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                merge_q  <= req_wdata;
                rdata_q  <= '0;
                funct3_q <= req_funct3;
                write_q  <= req_write;
                err_q    <= req_err_c;
            end
            if (state == LOAD) begin
                rdata_q <= extended_c;
            end
            if (state == RMW_READ) begin
                merge_q <= merged_c;
            end
        end
    end

    // Outputs are decodes of the state register and request latches
    always_comb begin
        req_ready        = (state == IDLE);
        resp_valid       = (state == RESP);
        resp_rdata       = (state == RESP && !write_q) ? rdata_q : '0;
        resp_err         = (state == RESP) && err_q;
        mem_address      = (state == IDLE) ? '0 : {addr_q[63:3], 3'b000};
        mem_write_enable = (state == WRITE);
        mem_write_data   = (state == WRITE) ? merge_q : '0;
    end

endmodule
